// File: rtl/sap_core_param.sv
// Parametrised SAP-class accumulator CPU: unified program/data RAM, carry and
// zero flags, conditional jumps, STA, program-load port and run/halt control.
module sap_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              halted,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_ADDR,
    S_F_INST,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  // Opcodes 8..D are not listed; they fall through as NOPs.
  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h3,
    OP_LDI = 4'h4,
    OP_JMP = 4'h5,
    OP_JC  = 4'h6,
    OP_JZ  = 4'h7,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } op_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  op_t               ir_op;
  logic [ADDR_W-1:0] ir_arg;
  logic [DATA_W-1:0] a;
  logic              c_flag;
  logic              z_flag;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // One extra bit on each ALU result carries the carry / borrow out.
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  assign mem_rd = mem[mar];

  always_comb begin
    sum  = {1'b0, a} + {1'b0, mem_rd};
    diff = {1'b0, a} - {1'b0, mem_rd};
  end

  // The IR only keeps the opcode and operand fields; the bits in between are
  // never looked at, so they are not stored.

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;
    if (state == S_EXEC2 && ir_op == OP_STA) begin
      mem_we    = 1'b1;
      mem_waddr = mar;
      mem_wdata = a;
    end else if ((state == S_IDLE || state == S_HALT) && prog_we) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the RAM array has no reset; program contents survive clr and the
  // array maps onto plain RAM without a per-word clear path.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      pc        <= '0;
      mar       <= '0;
      ir_op     <= OP_LDA;
      ir_arg    <= '0;
      a         <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_F_ADDR;
            busy  <= 1'b1;
          end
        end

        S_F_ADDR: begin
          mar   <= pc;
          state <= S_F_INST;
        end

        S_F_INST: begin
          ir_op  <= op_t'(mem_rd[DATA_W-1 -: 4]);
          ir_arg <= mem_rd[ADDR_W-1:0];
          pc     <= pc + ADDR_W'(1);
          state  <= S_EXEC1;
        end

        S_EXEC1: begin
          state <= S_F_ADDR;
          case (ir_op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar   <= ir_arg;
              state <= S_EXEC2;
            end
            OP_LDI: a <= {{(DATA_W-ADDR_W){1'b0}}, ir_arg};
            OP_JMP: pc <= ir_arg;
            OP_JC:  if (c_flag) pc <= ir_arg;
            OP_JZ:  if (z_flag) pc <= ir_arg;
            OP_OUT: begin
              out       <= a;
              out_valid <= 1'b1;
            end
            OP_HLT: begin
              state  <= S_HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end
            default: ;
          endcase
        end

        S_EXEC2: begin
          state <= S_F_ADDR;
          case (ir_op)
            OP_LDA: a <= mem_rd;
            OP_ADD: begin
              a      <= sum[DATA_W-1:0];
              c_flag <= sum[DATA_W];
              z_flag <= (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              // Carry set means no borrow, i.e. A >= M unsigned.
              a      <= diff[DATA_W-1:0];
              c_flag <= ~diff[DATA_W];
              z_flag <= (diff[DATA_W-1:0] == '0);
            end
            default: ;
          endcase
        end

        S_HALT: begin
          if (!run) begin
            state  <= S_IDLE;
            pc     <= '0;
            mar    <= '0;
            halted <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_core_param.sv
// Bench for sap_core_param: an instruction-level model predicts the per-cycle
// out/out_valid/busy/halted trace; directed programs exercise each feature.
module tb_sap_core_param;

  localparam int MAXC = 256;

  logic       clk = 1'b0;
  logic       clr;
  logic       run;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] out;
  logic       out_valid;
  logic       halted;
  logic       busy;

  logic        run_w;
  logic        prog_we_w;
  logic [5:0]  prog_addr_w;
  logic [11:0] prog_data_w;
  logic [11:0] out_w;
  logic        out_valid_w;
  logic        halted_w;
  logic        busy_w;

  always #5 clk = ~clk;

  sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out       (out),
    .out_valid (out_valid),
    .halted    (halted),
    .busy      (busy)
  );

  sap_core_param #(.DATA_W(12), .ADDR_W(6)) dut_w (
    .clk       (clk),
    .clr       (clr),
    .run       (run_w),
    .prog_we   (prog_we_w),
    .prog_addr (prog_addr_w),
    .prog_data (prog_data_w),
    .out       (out_w),
    .out_valid (out_valid_w),
    .halted    (halted_w),
    .busy      (busy_w)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  logic [7:0] img   [16];
  logic [7:0] m_mem [16];
  logic [7:0] m_a;
  logic [7:0] m_out;
  logic       m_c;
  logic       m_z;

  logic [7:0] e_out    [MAXC];
  bit         e_valid  [MAXC];
  bit         e_busy   [MAXC];
  bit         e_halted [MAXC];
  int         halt_cyc;

  task automatic model_reset();
    m_a = 8'h00; m_out = 8'h00; m_c = 1'b0; m_z = 1'b0;
  endtask

  // Cycle k is the state after the k-th edge, edge 0 being IDLE -> first fetch.
  // An instruction starting at t owns cycles t..t+len-1; OUT and HLT take
  // effect on edge t+3.
  task automatic model_run();
    int         t;
    int         len;
    int         s;
    bit         stop;
    logic [3:0] pc;
    logic [3:0] opd;
    logic [7:0] w;
    logic [7:0] mv;
    t = 0; stop = 0; pc = 4'd0; halt_cyc = -1;
    for (int k = 0; k < MAXC; k++) begin
      e_out[k] = m_out; e_valid[k] = 0; e_busy[k] = 1; e_halted[k] = 0;
    end
    for (int n = 0; n < 60 && !stop; n++) begin
      w   = m_mem[pc];
      opd = w[3:0];
      mv  = m_mem[opd];
      pc  = pc + 4'd1;
      len = 3;
      case (w[7:4])
        4'h0: begin m_a = mv; len = 4; end
        4'h1: begin
          s = int'(m_a) + int'(mv);
          m_c = (s > 255); m_a = 8'(s % 256); m_z = (m_a == 0); len = 4;
        end
        4'h2: begin
          m_c = (m_a >= mv);
          s = int'(m_a) - int'(mv) + 256;
          m_a = 8'(s % 256); m_z = (m_a == 0); len = 4;
        end
        4'h3: begin m_mem[opd] = m_a; len = 4; end
        4'h4: m_a = {4'h0, opd};
        4'h5: pc = opd;
        4'h6: if (m_c) pc = opd;
        4'h7: if (m_z) pc = opd;
        4'hE: begin
          m_out = m_a;
          for (int k = t + 3; k < MAXC; k++) e_out[k] = m_a;
          if (t + 3 < MAXC) e_valid[t+3] = 1;
        end
        4'hF: begin
          halt_cyc = t + 3;
          for (int k = t + 3; k < MAXC; k++) begin e_busy[k] = 0; e_halted[k] = 1; end
          stop = 1;
        end
        default: ;
      endcase
      t += len;
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  bit         cmp_en = 0;
  int         cyc = 0;
  int         first_pulse = -1;
  logic [7:0] pulse_val = 8'h00;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (cyc < MAXC) begin
        check($sformatf("c%0d out_valid", cyc), 32'(out_valid), 32'(e_valid[cyc]));
        check($sformatf("c%0d out", cyc), 32'(out), 32'(e_out[cyc]));
        check($sformatf("c%0d busy", cyc), 32'(busy), 32'(e_busy[cyc]));
        check($sformatf("c%0d halted", cyc), 32'(halted), 32'(e_halted[cyc]));
      end
      if (out_valid && first_pulse < 0) begin
        first_pulse = cyc;
        pulse_val   = out;
      end
      cyc++;
    end
  end

  task automatic load_img();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #2;
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = img[i];
      m_mem[i] = img[i];
    end
    @(negedge clk); #2;
    prog_we = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  // Runs the loaded program under the compare process. clobber drives prog_we
  // (addr 12, data 0) while the core is busy; abort_at >= 0 drops clr while
  // cycle abort_at is current.
  task automatic run_program(input bit clobber, input int abort_at);
    bit ended;
    ended = 0;
    model_run();
    @(negedge clk); #2;
    cyc = 0; first_pulse = -1; run = 1'b1; cmp_en = 1;
    for (int i = 0; i < MAXC - 4 && !ended; i++) begin
      @(negedge clk); #2;
      prog_we   = clobber && cyc >= 1 && cyc <= halt_cyc - 3;
      prog_addr = 4'd12;
      prog_data = 8'h00;
      if (abort_at >= 0 && cyc == abort_at + 1) ended = 1;
      if (abort_at < 0 && halt_cyc >= 0 && cyc >= halt_cyc + 2) ended = 1;
    end
    prog_we = 1'b0;
    cmp_en  = 0;
    if (!ended) check("run budget", 32'd0, 32'd1);
    if (abort_at >= 0) begin
      clr = 1'b0;
      #1;
      check("abort out", 32'(out), 32'h0);
      check("abort out_valid", 32'(out_valid), 32'h0);
      check("abort busy", 32'(busy), 32'h0);
      check("abort halted", 32'(halted), 32'h0);
      check("abort A", 32'(dut.a), 32'h0);
      check("abort C", 32'(dut.c_flag), 32'h0);
      check("abort PC", 32'(dut.pc), 32'h0);
      model_reset();
      run = 1'b0;
      @(negedge clk);
      clr = 1'b1;
    end else begin
      run = 1'b0;
      @(negedge clk);
      check("idle busy", 32'(busy), 32'h0);
      check("idle halted", 32'(halted), 32'h0);
      check("idle PC", 32'(dut.pc), 32'h0);
    end
  endtask

  logic [5:0]  wa [6] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd62, 6'd63};
  logic [11:0] wd [6] = '{12'h03E, 12'h13F, 12'hE00, 12'hF00, 12'h800, 12'h800};

  initial begin
    int         w_pulse;
    logic [11:0] w_val;
    clr = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    run_w = 1'b0; prog_we_w = 1'b0; prog_addr_w = '0; prog_data_w = '0;
    model_reset();
    #2;
    check("reset out", 32'(out), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset halted", 32'(halted), 32'h0);
    check("reset A", 32'(dut.a), 32'h0);
    check("reset PC", 32'(dut.pc), 32'h0);
    @(negedge clk);
    clr = 1'b1;

    // LDI 5, ADD 14, OUT, HLT with M[14]=3: out 8 after 3+4+3 cycles.
    clear_img();
    img[0] = 8'h45; img[1] = 8'h1E; img[2] = 8'hE0; img[3] = 8'hF0; img[14] = 8'h03;
    load_img();
    run_program(0, -1);
    check("p1 pulse cycle", 32'(first_pulse), 32'd10);
    check("p1 out", 32'(pulse_val), 32'h08);
    check("p1 C", 32'(dut.c_flag), 32'h0);
    check("p1 Z", 32'(dut.z_flag), 32'h0);

    // LDA 0xFF, ADD 1 -> 0, C=1, Z=1; JZ 9 then JC 11 both taken, OUT.
    clear_img();
    img[0] = 8'h0E; img[1] = 8'h1F; img[2] = 8'h79; img[9] = 8'h6B;
    img[10] = 8'hF0; img[11] = 8'hE0; img[12] = 8'hF0;
    img[14] = 8'hFF; img[15] = 8'h01;
    load_img();
    run_program(0, -1);
    check("carry pulse cycle", 32'(first_pulse), 32'd17);
    check("carry A", 32'(dut.a), 32'h00);
    check("carry C", 32'(dut.c_flag), 32'h1);
    check("carry Z", 32'(dut.z_flag), 32'h1);

    // Entered with Z=1: JZ 4, ADD 1, JMP 15, NOP@15 wraps to 0, JZ falls through.
    clear_img();
    img[0] = 8'h74; img[1] = 8'h47; img[2] = 8'hE0; img[3] = 8'hF0;
    img[4] = 8'h1E; img[5] = 8'h5F; img[14] = 8'h01; img[15] = 8'h80;
    load_img();
    run_program(0, -1);
    check("wrap pulse cycle", 32'(first_pulse), 32'd22);
    check("wrap out", 32'(pulse_val), 32'h07);

    // LDI 3, SUB 5 -> 0xFE with borrow; JC 5 not taken, OUT at 3.
    clear_img();
    img[0] = 8'h43; img[1] = 8'h2E; img[2] = 8'h65; img[3] = 8'hE0; img[4] = 8'hF0;
    img[5] = 8'h41; img[6] = 8'hE0; img[7] = 8'hF0; img[14] = 8'h05;
    load_img();
    run_program(0, -1);
    check("sub pulse cycle", 32'(first_pulse), 32'd13);
    check("sub out", 32'(pulse_val), 32'hFE);
    check("sub C", 32'(dut.c_flag), 32'h0);
    check("sub Z", 32'(dut.z_flag), 32'h0);

    // LDA 13 (0x5A), STA 12, LDI 0, LDA 12, OUT with prog_we hammering addr 12.
    clear_img();
    img[0] = 8'h0D; img[1] = 8'h3C; img[2] = 8'h40; img[3] = 8'h0C;
    img[4] = 8'hE0; img[5] = 8'hF0; img[13] = 8'h5A;
    load_img();
    run_program(1, -1);
    check("sta out", 32'(pulse_val), 32'h5A);
    check("sta ram", 32'(dut.mem[12]), 32'h5A);

    // Restart after reload: A=0x5A is retained, ADD 1 then OUT.
    clear_img();
    img[0] = 8'h1E; img[1] = 8'hE0; img[2] = 8'hF0; img[14] = 8'h01;
    load_img();
    run_program(0, -1);
    check("restart pulse cycle", 32'(first_pulse), 32'd7);
    check("restart out", 32'(pulse_val), 32'h5B);

    // LDI 2, ADD 14 (0xFE), STA 13; reset during ADD EXEC2, then during STA EXEC2.
    clear_img();
    img[0] = 8'h42; img[1] = 8'h1E; img[2] = 8'h3D; img[3] = 8'hF0;
    img[13] = 8'h77; img[14] = 8'hFE;
    load_img();
    run_program(0, 6);
    load_img();
    run_program(0, 10);
    @(negedge clk);
    check("abort sta ram", 32'(dut.mem[13]), 32'h77);

    // 12-bit data, 6-bit address: 0x800 + 0x800.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #2;
      prog_we_w = 1'b1; prog_addr_w = wa[i]; prog_data_w = wd[i];
    end
    @(negedge clk); #2;
    prog_we_w = 1'b0;
    @(negedge clk); #2;
    run_w = 1'b1;
    w_pulse = -1; w_val = 12'hFFF;
    for (int i = 0; i < 100 && !halted_w; i++) begin
      @(negedge clk);
      if (out_valid_w && w_pulse < 0) begin
        w_pulse = i; w_val = out_w;
      end
    end
    check("wide halted", 32'(halted_w), 32'h1);
    check("wide pulse cycle", 32'(w_pulse), 32'd11);
    check("wide out", 32'(w_val), 32'h000);
    check("wide A", 32'(dut_w.a), 32'h000);
    check("wide C", 32'(dut_w.c_flag), 32'h1);
    check("wide Z", 32'(dut_w.z_flag), 32'h1);
    run_w = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sap_core_param.md
# sap_core_param

Parametrised SAP-class accumulator CPU core with internal unified program/data RAM, a carry flag and a zero flag, conditional jumps, a store instruction and an output handshake. It succeeds the fixed 8-bit/4-bit-address SAP top level: same bus-style datapath (PC, MAR, IR, A, B/ALU, OUT), now generic in data and address width. It adds a program-load port and run/halt control, and sits directly under the FPGA top.

## Interface
- DATA_W, 8, memory word, accumulator and output width; must be ≥ ADDR_W+4
- ADDR_W, 4, address width; RAM depth is 2^ADDR_W words
- clk  in  1  system clock; all state updates on the rising edge
- clr  in  1  asynchronous, active-low reset (one clock; reset is async active-low)
- run  in  1  level; start or continue execution
- prog_we  in  1  RAM write strobe; honoured only in IDLE or HALT
- prog_addr  in  ADDR_W  RAM load address
- prog_data  in  DATA_W  RAM load data
- out  out  DATA_W  output register
- out_valid  out  1  one-cycle pulse when `out` is updated
- halted  out  1  high while in HALT
- busy  out  1  high in any FETCH or EXEC state

## Operation
- Instruction word layout:
  - opcode = word[DATA_W-1 -: 4]
  - operand = word[ADDR_W-1:0]
  - Bits in between are ignored.
- Opcodes:
  - 0 LDA: A←M[op]
  - 1 ADD: A←A+M[op]
  - 2 SUB: A←A−M[op]
  - 3 STA: M[op]←A
  - 4 LDI: A←zero-extended op
  - 5 JMP: PC←op
  - 6 JC: if C, PC←op
  - 7 JZ: if Z, PC←op
  - E OUT: out←A, pulse out_valid
  - F HLT
  - 8–D: NOP
- Flags:
  - C and Z are updated only by ADD and SUB.
  - ADD: C is the carry out of bit DATA_W-1.
  - SUB: C=1 means no borrow (A ≥ M, unsigned).
  - Z = (result == 0).
  - Result is truncated to DATA_W bits; wrap-around is silent.
- RAM: 2^ADDR_W × DATA_W, asynchronous read, synchronous write. Not cleared by reset.
- PC: ADDR_W bits; increments modulo 2^ADDR_W (top address wraps to 0).
- State machine states: IDLE, F_ADDR, F_INST, EXEC1, EXEC2, HALT.
  - IDLE: prog_we writes RAM. When run=1 → F_ADDR.
  - F_ADDR: MAR←PC → F_INST.
  - F_INST: IR←M[MAR], PC←PC+1 → EXEC1.
  - EXEC1, LDA/ADD/SUB/STA: MAR←operand → EXEC2.
  - EXEC1, LDI/JMP/JC/JZ/OUT/NOP: execute → F_ADDR.
  - EXEC1, HLT → HALT.
  - EXEC2: complete the memory operation → F_ADDR.
  - HALT: prog_we writes RAM. When run=0 → IDLE, with PC←0 and MAR←0. A, flags and out are retained.
- run deasserted while in F_ADDR…EXEC2: ignored. The core only stops on HLT or reset.
- prog_we outside IDLE/HALT: ignored; RAM is unchanged.
- STA and prog_we cannot collide, because prog_we is gated by state.

## Timing
- Reset (clr=0, asynchronous):
  - State → IDLE.
  - PC, MAR, IR, A, C, Z, out → 0.
  - out_valid, halted, busy → 0.
- Reset mid-instruction aborts immediately. A pending STA write or OUT pulse does not occur.
- Cycles per instruction, counted from the F_ADDR entry edge:
  - 3 cycles: LDI, JMP, JC, JZ, OUT, NOP.
  - 4 cycles: LDA, ADD, SUB, STA.
- From IDLE with run=1: F_ADDR begins on the next edge, then the first fetch proceeds.
- out and out_valid are registered. Both update on the edge that leaves EXEC1 for OUT; out_valid is high for exactly one cycle.
- Conditional jumps sample C/Z as they stand at EXEC1. A taken or untaken jump costs the same 3 cycles.
- halted rises on the edge entering HALT and falls on the edge leaving it.
- busy is low in IDLE and HALT.

## Test plan
- Default parameters. Load 0x45, 0x1E, 0xE0, 0xF0 at addresses 0–3 and M[14]=0x03, then set run=1.
  - Required: out=0x08 with one out_valid pulse, C=0, Z=0, then halted=1.
  - Required: 3+4+3 cycles from first F_ADDR to the OUT pulse.
- Carry and wrap: A=0xFF (LDI cannot reach it, so load it via LDA of 0xFF), then ADD of 0x01.
  - Required: A=0x00, C=1, Z=1.
  - Required: a following JZ 9 lands PC=9; JC is also taken.
- SUB borrow: A=3, SUB of 5.
  - Required: A=0xFE, C=0, Z=0.
  - Required: JC is not taken and PC advances sequentially.
- STA, OUT, and load-port gating:
  - Program STA 12 with A=0x5A, then LDA 12, OUT. Required: out=0x5A.
  - Assert prog_we to addr 12 with 0x00 while busy=1. Required: no effect.
- PC wrap and reset:
  - Place NOP at address 15 and LDI 7 / OUT / HLT at 0–2, and start with PC at 15 (reached via JMP 15). Required: PC wraps to 0 and out=0x07.
  - Drop clr during EXEC2 of an ADD. Required: all outputs go to 0 at once and no RAM write occurs.
- Halt/restart:
  - After HLT, run=0. Required: IDLE with PC=0.
  - Reload the RAM and set run=1. Required: execution restarts from address 0 with A retained from the prior run.
- DATA_W=12, ADDR_W=6: ADD 0x800+0x800. Required: A=0x000, C=1, Z=1.
